// File: rtl/cap_sched.sv
// Two-requester round-robin capture scheduler: grant, one-cycle capture strobe, then hold.
// Optional per-requester grant counters are enabled by defining CAP_SCHED_STATS_EN.
module cap_sched #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [3:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_data,
  output logic       req1_ready,
  output logic       cap_en,
  output logic [3:0] cap_data,
  output logic       cap_src,
  output logic       busy,
  output logic [3:0] q_out
`ifdef CAP_SCHED_STATS_EN
  ,
  output logic [7:0] gnt_cnt0,
  output logic [7:0] gnt_cnt1
`endif
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;
  localparam logic [3:0] LP_HOLD    = 4'(HOLD_CYCLES);

  logic [1:0] r_state;
  logic [3:0] r_hold_cnt;
  logic       r_ptr;
  logic       r_cap_en;
  logic [3:0] r_cap_data;
  logic       r_cap_src;
  logic       r_busy;
  logic [3:0] r_q_out;

  logic       w_any;
  logic       w_win;
  logic       w_hs;
  logic [3:0] w_win_data;

  // Under contention the requester not granted last wins; otherwise the lone valid one.
  assign w_any      = req0_valid | req1_valid;
  assign w_win      = (req0_valid && req1_valid) ? ~r_ptr : req1_valid;
  assign w_win_data = w_win ? req1_data : req0_data;
  assign w_hs       = rst && (r_state == ST_IDLE) && w_any;

  assign req0_ready = w_hs && !w_win;
  assign req1_ready = w_hs && w_win;

  assign cap_en   = r_cap_en;
  assign cap_data = r_cap_data;
  assign cap_src  = r_cap_src;
  assign busy     = r_busy;
  assign q_out    = r_q_out;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= 4'd0;
      r_ptr      <= 1'b1;
      r_cap_en   <= 1'b0;
      r_cap_data <= 4'd0;
      r_cap_src  <= 1'b0;
      r_busy     <= 1'b0;
      r_q_out    <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            r_state    <= ST_CAPTURE;
            r_ptr      <= w_win;
            r_cap_en   <= 1'b1;
            r_cap_data <= w_win_data;
            r_cap_src  <= w_win;
            r_busy     <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          r_cap_en <= 1'b0;
          r_q_out  <= r_cap_data;
          if (HOLD_CYCLES > 0) begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= LP_HOLD;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_HOLD: begin
          // Counter reaching 1 marks the last hold cycle.
          if (r_hold_cnt <= 4'd1) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= 4'd0;
            r_busy     <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CAP_SCHED_STATS_EN
  logic [7:0] r_gnt_cnt0;
  logic [7:0] r_gnt_cnt1;

  assign gnt_cnt0 = r_gnt_cnt0;
  assign gnt_cnt1 = r_gnt_cnt1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_gnt_cnt0 <= 8'd0;
      r_gnt_cnt1 <= 8'd0;
    end else begin
      if (req0_ready && (r_gnt_cnt0 != 8'hFF)) r_gnt_cnt0 <= r_gnt_cnt0 + 8'd1;
      if (req1_ready && (r_gnt_cnt1 != 8'hFF)) r_gnt_cnt1 <= r_gnt_cnt1 + 8'd1;
    end
  end
`endif

endmodule
